// File: rtl/mat_frame_loader_pkg.sv
// Shared constants, state encoding and element type for the matrix frame loader.
//   W          element width (signed two's complement, stored bit-exact)
//   NA / NB    A (4x2) and B (2x2) element counts per frame, row-major
//   FRAME_LEN  total elements per frame
//   ST_LOAD / ST_FULL  loader FSM encoding
package mat_frame_loader_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned NA        = 8;
  localparam int unsigned NB        = 4;
  localparam int unsigned FRAME_LEN = NA + NB;
  localparam int unsigned IDX_W     = 4;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Index of the final element of a frame (11).
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef logic [W-1:0] elem_t;

  // True when the element at this index must be the one tagged in_last.
  function automatic logic is_frame_end(input logic [IDX_W-1:0] idx);
    return idx == LAST_IDX;
  endfunction

endpackage

// File: rtl/mat_elem_regfile.sv
// Write-indexed element bank holding one A/B frame.
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_clr            synchronous clear of every entry (wins over a write)
//   i_we, i_widx     write enable and entry index (0..FRAME_LEN-1)
//   i_wdata          element to store
//   o_elems          all entries, registered, read out in parallel
module mat_elem_regfile
  import mat_frame_loader_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_we,
  input  logic [IDX_W-1:0]            i_widx,
  input  elem_t                       i_wdata,
  output elem_t [FRAME_LEN-1:0]       o_elems
);

  elem_t [FRAME_LEN-1:0] r_elems;

  // One decoded enable per entry; an index outside the bank writes nothing.
  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_entry
    logic w_sel;
    assign w_sel = i_we && (i_widx == IDX_W'(gi));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_elems[gi] <= '0;
      end else if (i_clr) begin
        r_elems[gi] <= '0;
      end else if (w_sel) begin
        r_elems[gi] <= i_wdata;
      end
    end
  end

  assign o_elems = r_elems;

endmodule

// File: rtl/mat_frame_loader.sv
// Serial-to-parallel frame loader feeding the 4x2 x 2x2 signed matrix multiplier.
// Collects 8 A elements then 4 B elements over a valid/ready stream, checks the
// in_last framing, and holds the completed frame stable until out_ready.
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_clear                      synchronous abort: drops partial/held frame, zeroes A/B
//   i_in_data/valid/last         element stream; o_in_ready accepts
//   o_a0..o_a7, o_b0..o_b3       registered operands (row-major)
//   o_out_valid, i_out_ready     frame handshake toward the product consumer
//   o_frame_err                  one-cycle pulse on a short or long frame
//   o_idx                        current element index 0..11
module mat_frame_loader
  import mat_frame_loader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [W-1:0]     i_in_data,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [W-1:0]     o_a0,
  output logic [W-1:0]     o_a1,
  output logic [W-1:0]     o_a2,
  output logic [W-1:0]     o_a3,
  output logic [W-1:0]     o_a4,
  output logic [W-1:0]     o_a5,
  output logic [W-1:0]     o_a6,
  output logic [W-1:0]     o_a7,
  output logic [W-1:0]     o_b0,
  output logic [W-1:0]     o_b1,
  output logic [W-1:0]     o_b2,
  output logic [W-1:0]     o_b3,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_frame_err,
  output logic [IDX_W-1:0] o_idx
);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_frame_err;
  logic                  w_frame_err_nxt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_at_end;
  logic                  w_good;
  logic                  w_bad;
  logic                  w_we;
  elem_t [FRAME_LEN-1:0] w_elems;

  // Ready is withheld while rst is asserted so nothing looks accepted during reset.
  assign w_in_ready = (r_state == ST_LOAD) && !i_rst;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_at_end   = is_frame_end(r_idx);

  // An element is well-framed when in_last coincides exactly with index 11.
  // Anything else is a short (early last) or long (missing last) frame.
  assign w_good = w_accept && (w_at_end == i_in_last);
  assign w_bad  = w_accept && (w_at_end != i_in_last);
  assign w_we   = w_good && !i_clear;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_frame_err_nxt = 1'b0;
    if (i_clear) begin
      w_state_nxt = ST_LOAD;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_good && w_at_end) begin
            w_state_nxt = ST_FULL;
            w_idx_nxt   = '0;
          end else if (w_good) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else if (w_bad) begin
            // Offending element is dropped; partial A/B contents are kept.
            w_idx_nxt       = '0;
            w_frame_err_nxt = 1'b1;
          end
        end
        ST_FULL: begin
          if (i_out_ready) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_LOAD;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  mat_elem_regfile u_regfile (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clear),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (i_in_data),
    .o_elems (w_elems)
  );

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == ST_FULL);
  assign o_frame_err = r_frame_err;
  assign o_idx       = r_idx;

  // Entries 0..7 are A (row-major 4x2), entries 8..11 are B (row-major 2x2).
  assign o_a0 = w_elems[0];
  assign o_a1 = w_elems[1];
  assign o_a2 = w_elems[2];
  assign o_a3 = w_elems[3];
  assign o_a4 = w_elems[4];
  assign o_a5 = w_elems[5];
  assign o_a6 = w_elems[6];
  assign o_a7 = w_elems[7];
  assign o_b0 = w_elems[NA + 0];
  assign o_b1 = w_elems[NA + 1];
  assign o_b2 = w_elems[NA + 2];
  assign o_b3 = w_elems[NA + 3];

endmodule
